uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (legal range 5..8).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 sample_tick  input  1  one-clk strobe at 16x baud rate; all bit timing advances only on cycles where it is 1.
REQ-005 rxd  input  1  asynchronous serial line; idle high; LSB-first frames of 1 start bit (0), DATA_BITS data bits, 1 stop bit (1).
REQ-006 rx_data  output  DATA_BITS  received byte in the holding register.
REQ-007 rx_valid  output  1  holding register full.
REQ-008 rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
REQ-009 frame_err  output  1  one-clk pulse on a bad stop bit.
REQ-010 overrun  output  1  one-clk pulse when a good frame is dropped because the holding register is full.
REQ-011 busy  output  1  high whenever state != IDLE.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rxs.
REQ-013 4-bit sample counter: cleared on every state transition; otherwise increments by 1 on sample_tick, wrapping 15->0; never increments in IDLE.
REQ-014 Bit-index counter: cleared on entry to DATA; increments once per data bit sampled.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE: on sample_tick with rxs==0 -> START.
REQ-017 START: on sample_tick with counter==7: rxs==0 -> DATA; rxs==1 -> IDLE (false start; no outputs affected).
REQ-018 DATA: on sample_tick with counter==15: shift rxs into the shift register MSB-side so the first bit ends in bit 0; bit index increments; after the DATA_BITS-th bit -> STOP.
REQ-019 STOP: on sample_tick with counter==15: rxs==1 -> good frame; rxs==0 -> frame_err=1 next cycle, byte discarded; either case -> IDLE.
REQ-020 Good frame with rx_valid==0, or rx_valid==1 && rx_ready==1 in the same cycle: rx_data loads the shifted byte and rx_valid is 1 next cycle.
REQ-021 Good frame with rx_valid==1 && rx_ready==0: byte discarded, rx_data unchanged, overrun=1 next cycle.
REQ-022 rx_valid && rx_ready without a completing frame: rx_valid clears next cycle; rx_data holds its value.
REQ-023 rx_valid and rx_data SHALL remain stable while rx_valid==1 && rx_ready==0.
REQ-024 Latency: rx_valid rises exactly one clk after the stop-bit sampling tick.
REQ-025 Line held low through STOP (break) produces frame_err; IDLE then requires a fresh rxs==0 tick, so a continuous break yields repeated frame_err every frame length.
REQ-026 sample_tick absent: FSM and counters hold indefinitely.

Reset
REQ-027 On rst: state=IDLE, both counters=0, shift register=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-028 rst has priority over every other event, including mid-frame and same-cycle accept; a partial frame is discarded.

Verification
REQ-029 Frame 0xA5, 16 ticks/bit, rx_ready=1 -> rx_data=0xA5, rx_valid one clk high, frame_err=0, overrun=0.
REQ-030 rxd low for 4 ticks then high -> returns to IDLE, busy drops, rx_valid/frame_err stay 0.
REQ-031 Frame 0x3C with stop bit 0 -> frame_err one-clk pulse, rx_valid stays 0.
REQ-032 Frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11 retained, overrun pulse after second stop tick.
REQ-033 rx_valid=1 (0x11), rx_ready=1 on the same cycle 0x22 completes -> rx_data=0x22, rx_valid stays 1, no overrun.
REQ-034 rst asserted in DATA after 3 bits, then frame 0x5A -> no output from aborted frame; rx_data=0x5A.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop line synchronizer, 16x oversampling start/data/stop FSM,
// and a one-entry holding register drained by a valid/ready consumer.
module uart_rx_ctrl #(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_tick,
   input  logic                 rxd,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy,
   output logic [1:0]           state
);

   // Handshake: rx_data is taken when rx_valid && rx_ready on a rising clk edge;
   // while rx_valid is high and rx_ready low, rx_valid and rx_data are held.

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   state_t               st;
   state_t               st_nxt;
   logic                 rx_meta;
   logic                 rxs;
   logic [3:0]           cnt;
   logic [3:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 shift_en;
   logic                 stop_eval;
   logic                 good_frame;

   always_ff @(posedge clk) begin
      if (rst) st <= IDLE;
      else     st <= st_nxt;
   end

   always_comb begin
      st_nxt    = st;
      shift_en  = 1'b0;
      stop_eval = 1'b0;
      if (sample_tick) begin
         case (st)
            IDLE:  if (!rxs) st_nxt = START;
            // Mid-point of the start bit re-checks the line to reject glitches.
            START: if (cnt == 4'd7) st_nxt = rxs ? IDLE : DATA;
            DATA:  if (cnt == 4'd15) begin
                      shift_en = 1'b1;
                      if (bit_idx == LAST_BIT) st_nxt = STOP;
                   end
            STOP:  if (cnt == 4'd15) begin
                      stop_eval = 1'b1;
                      st_nxt    = IDLE;
                   end
            default: st_nxt = IDLE;
         endcase
      end
   end

   assign good_frame = stop_eval && rxs;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta   <= 1'b1;
         rxs       <= 1'b1;
         cnt       <= 4'd0;
         bit_idx   <= 4'd0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         rx_meta <= rxd;
         rxs     <= rx_meta;

         if (st_nxt != st)                    cnt <= 4'd0;
         else if (sample_tick && st != IDLE)  cnt <= cnt + 4'd1;

         if (st_nxt == DATA && st != DATA) bit_idx <= 4'd0;
         else if (shift_en)                bit_idx <= bit_idx + 4'd1;

         // LSB arrives first, so shifting in from the top leaves it in bit 0.
         if (shift_en) shreg <= {rxs, shreg[DATA_BITS-1:1]};

         frame_err <= stop_eval && !rxs;
         overrun   <= good_frame && rx_valid && !rx_ready;

         if (good_frame && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign busy  = (st != IDLE);
   assign state = st;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames driven at 16 ticks per bit, one tick every other clk.
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_tick;
   logic       rxd;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;
   logic [1:0] state;

   int n_checks = 0;
   int n_errors = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;
   int fe_snap;

   uart_rx_ctrl #(.DATA_BITS(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .rxd         (rxd),
      .rx_ready    (rx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .busy        (busy),
      .state       (state)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun)   ov_cnt <= ov_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_tick();
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
   endtask

   task automatic do_tick_rdy(input logic r, input logic r_after);
      @(negedge clk);
      sample_tick = 1'b1;
      rx_ready    = r;
      @(negedge clk);
      sample_tick = 1'b0;
      rx_ready    = r_after;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) do_tick();
   endtask

   // Drives start, data and the stop level up to just before the stop sampling tick.
   task automatic send_to_stop(input logic [7:0] d, input logic stop_val);
      rxd = 1'b0;
      ticks(16);
      for (int b = 0; b < 8; b++) begin
         rxd = d[b];
         ticks(16);
      end
      rxd = stop_val;
      ticks(9);
   endtask

   task automatic finish_frame();
      rxd = 1'b1;
      ticks(6);
   endtask

   initial begin
      rst         = 1'b1;
      sample_tick = 1'b0;
      rxd         = 1'b1;
      rx_ready    = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", state, 2'd0);
      check("reset_busy", busy, 1'b0);
      check("reset_valid", rx_valid, 1'b0);
      check("reset_data", rx_data, 8'h00);
      check("reset_ferr", frame_err, 1'b0);
      check("reset_ovr", overrun, 1'b0);
      rst = 1'b0;
      ticks(4);

      // Good frame 0xA5 with consumer ready.
      rx_ready = 1'b1;
      send_to_stop(8'hA5, 1'b1);
      check("a5_pre_stop_valid", rx_valid, 1'b0);
      check("a5_pre_stop_busy", busy, 1'b1);
      do_tick();
      check("a5_valid", rx_valid, 1'b1);
      check("a5_data", rx_data, 8'hA5);
      check("a5_ferr", frame_err, 1'b0);
      @(negedge clk);
      check("a5_valid_one_clk", rx_valid, 1'b0);
      check("a5_data_hold", rx_data, 8'hA5);
      finish_frame();
      check("a5_no_ferr_total", fe_cnt, 0);
      check("a5_no_ovr_total", ov_cnt, 0);

      // False start: 4 low ticks then high.
      rxd = 1'b0;
      ticks(4);
      rxd = 1'b1;
      check("false_start_busy", busy, 1'b1);
      ticks(12);
      check("false_start_idle", busy, 1'b0);
      check("false_start_valid", rx_valid, 1'b0);
      check("false_start_ferr", fe_cnt, 0);

      // Bad stop bit on 0x3C.
      send_to_stop(8'h3C, 1'b0);
      do_tick();
      check("ferr_pulse", frame_err, 1'b1);
      check("ferr_valid", rx_valid, 1'b0);
      @(negedge clk);
      check("ferr_pulse_end", frame_err, 1'b0);
      finish_frame();
      check("ferr_total", fe_cnt, 1);
      check("ferr_data_kept", rx_data, 8'hA5);

      // Overrun: 0x11 then 0x22 with consumer stalled.
      rx_ready = 1'b0;
      send_to_stop(8'h11, 1'b1);
      do_tick();
      check("ovr_first_valid", rx_valid, 1'b1);
      check("ovr_first_data", rx_data, 8'h11);
      finish_frame();
      send_to_stop(8'h22, 1'b1);
      check("ovr_stall_data", rx_data, 8'h11);
      do_tick();
      check("ovr_pulse", overrun, 1'b1);
      check("ovr_data_kept", rx_data, 8'h11);
      check("ovr_valid_kept", rx_valid, 1'b1);
      @(negedge clk);
      check("ovr_pulse_end", overrun, 1'b0);
      finish_frame();

      // Accept on the same cycle a new frame completes.
      send_to_stop(8'h22, 1'b1);
      do_tick_rdy(1'b1, 1'b0);
      check("same_cycle_valid", rx_valid, 1'b1);
      check("same_cycle_data", rx_data, 8'h22);
      check("same_cycle_no_ovr", overrun, 1'b0);
      finish_frame();
      check("same_cycle_ovr_total", ov_cnt, 1);
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check("consume_valid", rx_valid, 1'b0);
      check("consume_data_hold", rx_data, 8'h22);

      // Reset mid-DATA after 3 bits, with a stall (no ticks) first.
      fe_snap = fe_cnt;
      rxd = 1'b0;
      ticks(16);
      for (int b = 0; b < 3; b++) begin
         rxd = (b == 1);
         ticks(16);
      end
      repeat (30) @(negedge clk);
      check("no_tick_hold_state", state, 2'd2);
      rst = 1'b1;
      rxd = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("midframe_rst_state", state, 2'd0);
      check("midframe_rst_data", rx_data, 8'h00);
      ticks(4);
      send_to_stop(8'h5A, 1'b1);
      do_tick();
      check("after_rst_valid", rx_valid, 1'b1);
      check("after_rst_data", rx_data, 8'h5A);
      finish_frame();
      check("after_rst_no_ferr", fe_cnt, fe_snap);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
